serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial N-bit subtractor. Computes (A - B - Bin) mod 2^N one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow
// flip-flop. A start/busy/done handshake lets a controller drive it.
//
// Parameters:
//   N        operand/result width in bits (N >= 2)
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  request a new operation (sampled only in IDLE)
//   i_a      minuend, captured on the accepted start edge
//   i_b      subtrahend, captured on the accepted start edge
//   i_bin    borrow-in, captured on the accepted start edge
//   o_busy   high whenever the unit is not IDLE
//   o_done   one-cycle pulse, result valid
//   o_diff   (A - B - Bin) mod 2^N, valid from done until the next start
//   o_bout   borrow-out, 1 iff A < B + Bin (unsigned)
//   o_ovf    signed overflow flag, present only when OVF_FLAG_EN is defined
//
// Optional feature macro: OVF_FLAG_EN
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_diff,
  output logic         o_bout
`ifdef OVF_FLAG_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_diff;
  logic          r_brw;
  logic          r_bout;
  logic          w_ai;
  logic          w_bi;
  logic          w_d;
  logic          w_brwNext;
  logic          w_lastBit;
  logic          w_accept;

  // The operand registers shift right every RUN cycle, so the bit being
  // processed is always at position 0. The full-subtractor cell works on
  // that bit pair plus the stored borrow.
  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_brw;
  assign w_brwNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);
  assign w_lastBit = (r_count == CW'(N - 1));
  assign w_accept  = (r_state == S_IDLE) && i_start;

  assign o_diff = r_diff;
  assign o_bout = r_bout;

  // State register. Reset drops straight back to IDLE, which also aborts any
  // operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake outputs. start is only looked at in IDLE, so a
  // start raised while RUN or DONE is simply dropped, not queued.
  always_comb begin
    w_stateNext = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_lastBit) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath. On an accepted start the operands are latched and Bin seeds the
  // borrow flip-flop. Each RUN cycle produces one difference bit, which enters
  // the result register from the MSB side so that after N shifts bit 0 has
  // arrived at o_diff[0]. The result register is left alone outside RUN, so
  // the finished value holds until the next operation starts shifting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_brw   <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_brw   <= i_bin;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_brw   <= w_brwNext;
      r_diff  <= {w_d, r_diff[N-1:1]};
      r_count <= r_count + CW'(1);
      if (w_lastBit) begin
        r_bout <= w_brwNext;
      end
    end
  end

`ifdef OVF_FLAG_EN
  logic r_ovf;

  assign o_ovf = r_ovf;

  // Signed overflow is decided on the final bit: the operand sign bits are
  // the ones sitting at position 0 of the shift registers right now, and the
  // result sign bit is the difference bit being produced this cycle.
  // Overflow happens when the operand signs differ and the result sign does
  // not match the minuend sign.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_lastBit) begin
      r_ovf <= (w_ai ^ w_bi) & (w_d ^ w_ai);
    end
  end
`endif

endmodule
